// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
// Funct3 codes, FSM states and default bus timeout.
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       is_load,
    input logic [2:0] f3
  );
    if (is_load)
      return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Single-beat data bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables and replication,
// load byte/half extract with extension, misalignment detect.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        i_access,
  input  logic        i_is_load,
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic       w_legal;
  logic       w_bad_h;
  logic       w_bad_w;
  logic [7:0] w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_legal = f3_legal(i_is_load, i_f3);
    w_bad_h = (i_f3[1:0] == 2'b01) && i_off[0];
    w_bad_w = (i_f3[1:0] == 2'b10) && (i_off != 2'b00);
    o_misalign = i_access && (!w_legal || w_bad_h || w_bad_w);
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    unique case (1'b1)
      (i_f3[1:0] == 2'b00): begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_f3[1:0] == 2'b01): begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_ld_off)
      2'b00: w_byte = i_rdata[7:0];
      2'b01: w_byte = i_rdata[15:8];
      2'b10: w_byte = i_rdata[23:16];
      2'b11: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_ld_data = i_rdata;
    unique case (i_ld_f3)
      F3_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:  o_ld_data = {{16{w_half[15]}}, w_half};
      F3_BU: o_ld_data = {24'd0, w_byte};
      F3_HU: o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: turns MemRead/MemWrite into one bus beat,
// stalls the pipe until ack or timeout, registers the load result.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemReadM,
  input  logic                   MemWriteM,
  input  logic [2:0]             Funct3M,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic                   StallM,
  output logic                   MisalignM,
  output logic                   BusErrM,
  mem_stage_lsu_if.master        bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e r_state;
  lsu_state_e w_nxt;

  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic             r_ld;
  logic [2:0]       r_ld_f3;
  logic [1:0]       r_off;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic        w_access;
  logic        w_is_load;
  logic        w_mis;
  logic        w_start;
  logic        w_in_bus;
  logic        w_ack_hit;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;

  assign w_access  = MemReadM | MemWriteM;
  assign w_is_load = MemReadM;

  lsu_align u_align (
    .i_access   (w_access),
    .i_is_load  (w_is_load),
    .i_f3       (Funct3M),
    .i_off      (ALUResultM[1:0]),
    .i_wdata    (WriteDataM),
    .o_misalign (w_mis),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_f3    (r_ld_f3),
    .i_ld_off   (r_off),
    .i_rdata    (bus.rdata),
    .o_ld_data  (w_ld_data)
  );

  assign w_start   = (r_state == ST_IDLE) && w_access && !w_mis;
  assign w_in_bus  = (r_state == ST_BUS);
  assign w_ack_hit = w_in_bus && bus.ack;
  // A zero TIMEOUT waits for ack forever.
  assign w_tmo     = w_in_bus && !bus.ack && (TIMEOUT != 0)
                     && (r_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    StallM = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        StallM = w_start;
        if (w_start) w_nxt = ST_BUS;
      end
      ST_BUS: begin
        StallM = 1'b1;
        if (w_ack_hit || w_tmo) w_nxt = ST_DONE;
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_ld    <= 1'b0;
      r_ld_f3 <= '0;
      r_off   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_err <= w_tmo;
      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= !w_is_load;
        r_addr  <= {ALUResultM[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_is_load ? 32'd0 : w_wdata;
        r_ld    <= w_is_load;
        r_ld_f3 <= Funct3M;
        r_off   <= ALUResultM[1:0];
        r_cnt   <= '0;
      end else if (w_in_bus) begin
        if (w_ack_hit) begin
          r_req <= 1'b0;
          if (r_ld) r_rdata <= w_ld_data;
        end else if (w_tmo) begin
          r_req   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.req    = r_req;
  assign bus.we     = r_we;
  assign bus.addr   = r_addr;
  assign bus.be     = r_be;
  assign bus.wdata  = r_wdata;
  assign ReadDataM  = r_rdata;
  assign BusErrM    = r_err;
  assign MisalignM  = w_mis;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
// Inputs change on negedge; outputs sampled 1ns later.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'd0;
  logic [31:0] WriteDataM = 32'd0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          o_stalls;
  int          o_reqs;
  logic        o_mis;
  logic        o_to;
  logic [31:0] o_rd;
  logic        o_err;
  logic        o_req_end;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wd;
  logic        o_we;

  // Drives one access and records what the DUT did; lat<0 = no ack.
  task automatic do_access(
    input logic        rd,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rdat,
    input int          lat
  );
    int busc;
    bit seen;
    @(negedge clk);
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    bus.ack    = 1'b0;
    bus.rdata  = rdat;
    o_stalls = 0;
    o_reqs   = 0;
    o_addr   = 32'hx;
    o_be     = 4'hx;
    o_wd     = 32'hx;
    o_we     = 1'bx;
    busc = 0;
    seen = 0;
    o_to = 1'b1;
    #1;
    o_mis = MisalignM;
    for (int n = 0; n < 64; n++) begin
      if (!StallM) begin
        o_to = 1'b0;
        break;
      end
      o_stalls++;
      if (bus.req) begin
        o_reqs++;
        if (!seen) begin
          o_addr = bus.addr;
          o_be   = bus.be;
          o_wd   = bus.wdata;
          o_we   = bus.we;
        end
        seen = 1;
        bus.ack = (busc == lat);
        busc++;
      end
      @(negedge clk);
      #1;
    end
    o_rd      = ReadDataM;
    o_err     = BusErrM;
    o_req_end = bus.req;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    bus.ack   = 1'b0;
    checks++;
    if (o_to !== 1'b0) begin
      errors++;
      $display("FAIL access_budget got stalls=%0d req 64 cycles",
               o_stalls);
    end
  endtask

  task automatic test_reset();
    bus.ack   = 1'b0;
    bus.rdata = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req !== 1'b0) begin
      errors++; $display("FAIL rst_req got %b exp 0", bus.req);
    end
    checks++;
    if (bus.be !== 4'h0 || bus.we !== 1'b0) begin
      errors++;
      $display("FAIL rst_be_we got %h/%b exp 0/0", bus.be, bus.we);
    end
    checks++;
    if (bus.addr !== 32'd0 || bus.wdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_addr_wd got %h/%h exp 0/0",
               bus.addr, bus.wdata);
    end
    checks++;
    if (ReadDataM !== 32'd0 || BusErrM !== 1'b0) begin
      errors++;
      $display("FAIL rst_rd_err got %h/%b exp 0/0",
               ReadDataM, BusErrM);
    end
    checks++;
    if (StallM !== 1'b0 || MisalignM !== 1'b0) begin
      errors++;
      $display("FAIL rst_stall got %b/%b exp 0/0", StallM, MisalignM);
    end
  endtask

  task automatic test_lw();
    do_access(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0);
    checks++;
    if (o_stalls !== 2) begin
      errors++; $display("FAIL lw_stalls got %0d exp 2", o_stalls);
    end
    checks++;
    if (o_addr !== 32'h100 || o_be !== 4'hF || o_we !== 1'b0) begin
      errors++;
      $display("FAIL lw_bus got %h/%h/%b exp 100/f/0",
               o_addr, o_be, o_we);
    end
    checks++;
    if (o_rd !== 32'hDEADBEEF || o_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_data got %h/%b exp deadbeef/0", o_rd, o_err);
    end
    checks++;
    if (o_reqs !== 1 || o_req_end !== 1'b0) begin
      errors++;
      $display("FAIL lw_req got %0d/%b exp 1/0", o_reqs, o_req_end);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s[3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] as[3]  = '{32'h202, 32'h201, 32'h300};
    logic [31:0] wds[3] = '{32'h1234ABCD, 32'h00000077, 32'hCAFEF00D};
    logic [31:0] eas[3] = '{32'h200, 32'h200, 32'h300};
    logic [3:0]  ebe[3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ewd[3] = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      do_access(0, 1, f3s[i], as[i], wds[i], 32'h0, 0);
      checks++;
      if (o_we !== 1'b1 || o_addr !== eas[i] || o_be !== ebe[i]) begin
        errors++;
        $display("FAIL st%0d_bus got we=%b a=%h be=%b exp 1/%h/%b",
                 i, o_we, o_addr, o_be, eas[i], ebe[i]);
      end
      checks++;
      if (o_wd !== ewd[i]) begin
        errors++;
        $display("FAIL st%0d_wdata got %h exp %h", i, o_wd, ewd[i]);
      end
      checks++;
      if (o_stalls !== 2 || o_rd !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL st%0d_hold got stalls=%0d rd=%h exp 2/deadbeef",
                 i, o_stalls, o_rd);
      end
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s[6] = '{3'b000, 3'b100, 3'b001,
                            3'b101, 3'b000, 3'b001};
    logic [31:0] as[6]  = '{32'h103, 32'h103, 32'h102,
                            32'h100, 32'h102, 32'h100};
    logic [31:0] rds[6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                            32'h1234ABCD, 32'h80FF0000, 32'h00008001};
    logic [31:0] exp[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                            32'h0000ABCD, 32'hFFFFFFFF, 32'hFFFF8001};
    for (int i = 0; i < 6; i++) begin
      do_access(1, 0, f3s[i], as[i], 32'd0, rds[i], 0);
      checks++;
      if (o_rd !== exp[i] || o_stalls !== 2) begin
        errors++;
        $display("FAIL ld%0d_ext got %h stalls=%0d exp %h/2",
                 i, o_rd, o_stalls, exp[i]);
      end
    end
    do_access(1, 0, 3'b010, 32'h10C, 32'd0, 32'h0, 0);
    checks++;
    if (o_addr !== 32'h10C) begin
      errors++; $display("FAIL ld_addr got %h exp 10c", o_addr);
    end
  endtask

  task automatic test_both();
    do_access(1, 1, 3'b100, 32'h101, 32'hFFFFFFFF, 32'h0000A500, 0);
    checks++;
    if (o_mis !== 1'b0 || o_we !== 1'b0 || o_rd !== 32'h000000A5) begin
      errors++;
      $display("FAIL both_is_load got mis=%b we=%b rd=%h exp 0/0/a5",
               o_mis, o_we, o_rd);
    end
  endtask

  task automatic test_misalign();
    logic        rds[5] = '{1, 1, 1, 0, 0};
    logic [2:0]  f3s[5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001};
    logic [31:0] as[5]  = '{32'h101, 32'h103, 32'h100,
                            32'h100, 32'h201};
    for (int i = 0; i < 5; i++) begin
      do_access(rds[i], !rds[i], f3s[i], as[i], 32'h0, 32'h0, 0);
      checks++;
      if (o_mis !== 1'b1 || o_stalls !== 0) begin
        errors++;
        $display("FAIL mis%0d got mis=%b stalls=%0d exp 1/0",
                 i, o_mis, o_stalls);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.req !== 1'b0 || o_reqs !== 0) begin
        errors++;
        $display("FAIL mis%0d_req got %b/%0d exp 0/0",
                 i, bus.req, o_reqs);
      end
    end
  endtask

  task automatic test_ack_latency();
    do_access(1, 0, 3'b010, 32'h104, 32'd0, 32'h01020304, 2);
    checks++;
    if (o_stalls !== 4 || o_reqs !== 3 || o_rd !== 32'h01020304) begin
      errors++;
      $display("FAIL lat2 got stalls=%0d reqs=%0d rd=%h exp 4/3/01020304",
               o_stalls, o_reqs, o_rd);
    end
  endtask

  task automatic test_timeout();
    do_access(1, 0, 3'b010, 32'h108, 32'd0, 32'h55555555, -1);
    checks++;
    if (o_reqs !== 16 || o_stalls !== 17) begin
      errors++;
      $display("FAIL tmo_len got reqs=%0d stalls=%0d exp 16/17",
               o_reqs, o_stalls);
    end
    checks++;
    if (o_err !== 1'b1 || o_rd !== 32'd0 || o_req_end !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err got err=%b rd=%h req=%b exp 1/0/0",
               o_err, o_rd, o_req_end);
    end
    @(negedge clk); #1;
    checks++;
    if (BusErrM !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse got %b exp 0", BusErrM);
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    bus.rdata = 32'hFFFFFFFF;
    bus.ack   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'd0) begin
      errors++;
      $display("FAIL idle_ack got req=%b stall=%b rd=%h exp 0/0/0",
               bus.req, StallM, ReadDataM);
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemReadM   = 1'b1;
    Funct3M    = 3'b010;
    ALUResultM = 32'h400;
    bus.ack    = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.req !== 1'b1) begin
      errors++; $display("FAIL rmid_busreq got %b exp 1", bus.req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.req !== 1'b0 || BusErrM !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async got req=%b err=%b exp 0/0",
               bus.req, BusErrM);
    end
    MemReadM = 1'b0;
    #1;
    checks++;
    if (StallM !== 1'b0) begin
      errors++; $display("FAIL rmid_idle got stall=%b exp 0", StallM);
    end
    @(negedge clk);
    rst = 1'b0;
    do_access(1, 0, 3'b010, 32'h104, 32'd0, 32'h11223344, 0);
    checks++;
    if (o_stalls !== 2 || o_rd !== 32'h11223344 || o_addr !== 32'h104) begin
      errors++;
      $display("FAIL rmid_next got stalls=%0d rd=%h a=%h exp 2/11223344/104",
               o_stalls, o_rd, o_addr);
    end
  endtask

  task automatic test_back_to_back();
    do_access(0, 1, 3'b010, 32'h108, 32'h55AA55AA, 32'h0, 0);
    checks++;
    if (o_stalls !== 2 || o_we !== 1'b1 || o_wd !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL b2b_sw got stalls=%0d we=%b wd=%h exp 2/1/55aa55aa",
               o_stalls, o_we, o_wd);
    end
    do_access(1, 0, 3'b010, 32'h108, 32'h0, 32'h55AA55AA, 0);
    checks++;
    if (o_stalls !== 2 || o_rd !== 32'h55AA55AA || o_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lw got stalls=%0d rd=%h we=%b exp 2/55aa55aa/0",
               o_stalls, o_rd, o_we);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_store();
    test_load_ext();
    test_both();
    test_misalign();
    test_ack_latency();
    test_timeout();
    test_spurious_ack();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit between the EX/MEM register and the MEM/WB register.
- Turns MemRead/MemWrite requests into single-beat data-bus transactions with byte enables.
- Aligns and sign/zero-extends load data into ReadDataM.
- Stalls the pipeline, via StallM, until the bus transaction completes.

Parameters:
- TIMEOUT, 16, max cycles waiting for bus_ack before a bus error is flagged; 0 disables the timeout.
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- MemReadM  in  1  load request
- MemWriteM  in  1  store request
- Funct3M  in  3  access size/sign (RV32I funct3)
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (rs2)
- ReadDataM  out  32  aligned, extended load result (registered)
- StallM  out  1  hold upstream stages and MEM/WB EN low while 1
- MisalignM  out  1  misaligned or illegal-funct3 access (combinational)
- BusErrM  out  1  timeout error for the completing access (registered, 1 cycle)
- bus_req  out  1  transaction request (registered)
- bus_we  out  1  write strobe
- bus_addr  out  32  word address, bits [1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, ReadDataM, BusErrM, timeout counter all 0.
  - StallM follows its equation (0 with no request).
  - A reset mid-transaction drops bus_req immediately, with no completion.
- Access = MemReadM|MemWriteM. If both are set, treat as a load.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
- MisalignM=1 when access is set and any of:
  - funct3 is illegal;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- On MisalignM: no bus transaction, StallM=0, the pipeline proceeds. Flagging the trap is downstream's job.
- States:
  - IDLE: on a legal access, latch request fields into bus outputs and set bus_req=1 next cycle, then go to BUS.
  - BUS: bus_req stays 1 with fields stable. On bus_ack:
    - bus_req=0 next cycle;
    - for a load, ReadDataM <= extended bus_rdata;
    - go to DONE.
    - Timeout: if the counter reaches TIMEOUT without bus_ack, bus_req=0, ReadDataM=0, BusErrM=1, go to DONE.
  - DONE: one cycle, StallM=0 so MEM/WB captures the result. Go to IDLE, where a new access may start the same cycle (back-to-back).
- StallM = (IDLE & access & !MisalignM) | BUS. Minimum 2 stall cycles per access; ack in the first BUS cycle completes fastest.
- Store lanes:
  - SB: be = 1<<addr[1:0]; wdata = {4{WriteDataM[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111.
- Load lanes: select byte/half by addr[1:0]; sign-extend for funct3 000/001, zero-extend for 100/101.
- ReadDataM holds its value outside load completion. Store completion leaves ReadDataM unchanged.
- bus_ack outside BUS is ignored.
- The timeout counter clears on entering BUS.

Decomposition:
- Shared package:
  - funct3 load/store encodings;
  - state encoding (IDLE/BUS/DONE);
  - default TIMEOUT.
- Sub-module lsu_align (combinational):
  - store byte-enable and lane replication;
  - load extract and extend;
  - misalign detect.
- FSM, timeout counter and bus registers stay in mem_stage_lsu.

Test Plan:
- LW addr 0x100, bus_rdata=0xDEADBEEF, ack on first BUS cycle:
  - bus_addr=0x100, be=1111;
  - StallM high 2 cycles;
  - ReadDataM=0xDEADBEEF in DONE.
- LB addr 0x103, rdata=0x80FF_0000 -> be irrelevant, ReadDataM=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x202, WriteDataM=0x1234ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- LW addr 0x101 -> MisalignM=1, StallM=0, bus_req never asserted.
- LW with no ack, TIMEOUT=16 -> bus_req drops after 16 BUS cycles, BusErrM=1 for one cycle, ReadDataM=0.
- rst pulsed during BUS -> bus_req=0 asynchronously, state IDLE. Next LW completes normally. Back-to-back SW then LW both complete with 2 stall cycles each.
